// File: rtl/seqcheck_pkg.sv
// seqcheck_pkg: shared sizing helpers and event bundle
// for the sequence-check event path.
package seqcheck_pkg;

  localparam int MAX_CH_W  = 4;
  localparam int MAX_CNT_W = 16;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  typedef struct packed {
    logic [MAX_CH_W-1:0]  ch;
    logic [MAX_CNT_W-1:0] cnt;
    logic                 sat;
  } evt_t;

endpackage

// File: rtl/seqcheck_event_arb_if.sv
// seqcheck_event_arb_if: valid/ready event stream
// from the arbiter to the event consumer.
interface seqcheck_event_arb_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 4
);
  logic             evt_valid;
  logic             evt_ready;
  logic [CH_W-1:0]  evt_ch;
  logic [CNT_W-1:0] evt_cnt;
  logic             evt_sat;

  modport master (
    output evt_valid, evt_ch, evt_cnt, evt_sat,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_ch, evt_cnt, evt_sat,
    output evt_ready
  );
endinterface

// File: rtl/seqcheck_rr_pick.sv
// seqcheck_rr_pick: combinational rotate-priority pick,
// first set req at or above ptr, wrapping.
module seqcheck_rr_pick
  import seqcheck_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic            gnt_valid,
  output logic [CH_W-1:0] gnt_idx
);

  int j;

  // Scan from the far end so the nearest offset wins last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N_CH;
      if (req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = CH_W'(j);
      end
    end
  end

endmodule

// File: rtl/seqcheck_event_arb.sv
// seqcheck_event_arb: coalesces per-channel hit pulses and
// serialises them round-robin onto one event stream.
module seqcheck_event_arb
  import seqcheck_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] hit,
  input  logic [N_CH-1:0] ch_en,
  output logic [N_CH-1:0] pending,
  seqcheck_event_arb_if.master evt
);

  localparam int CH_W = ch_w(N_CH);
  localparam logic [CNT_W-1:0] CMAX =
    CNT_W'(cnt_max(CNT_W));

  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  sat_q, sat_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  req;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  gnt_idx;
  logic             gnt_valid;
  logic             load;
  logic             take;

  logic             v_q;
  logic [CH_W-1:0]  ch_q;
  logic [CNT_W-1:0] cnt_o_q;
  logic             sat_o_q;

  // Disabled channels never compete, even if pend is still set.
  assign req  = pend_q & ch_en;
  assign load = !v_q || evt.evt_ready;
  assign take = load && gnt_valid;

  seqcheck_rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_pick (
    .req       (req),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Grant clears first so a same-cycle hit restarts at 1.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      pend_d[i] = pend_q[i];
      cnt_d[i]  = cnt_q[i];
      sat_d[i]  = sat_q[i];
      if (!ch_en[i]) begin
        pend_d[i] = 1'b0;
        cnt_d[i]  = '0;
        sat_d[i]  = 1'b0;
      end else begin
        if (take && gnt_idx == CH_W'(i)) begin
          pend_d[i] = 1'b0;
          cnt_d[i]  = '0;
          sat_d[i]  = 1'b0;
        end
        if (hit[i]) begin
          if (!pend_d[i]) begin
            pend_d[i] = 1'b1;
            cnt_d[i]  = CNT_W'(1);
            sat_d[i]  = 1'b0;
          end else if (cnt_d[i] == CMAX) begin
            sat_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_d[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      sat_q  <= '0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      sat_q  <= sat_d;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= 1'b0;
      ch_q    <= '0;
      cnt_o_q <= '0;
      sat_o_q <= 1'b0;
      rr_ptr  <= '0;
    end else if (load) begin
      v_q <= gnt_valid;
      if (gnt_valid) begin
        ch_q    <= gnt_idx;
        cnt_o_q <= cnt_q[gnt_idx];
        sat_o_q <= sat_q[gnt_idx];
        rr_ptr  <= (gnt_idx == CH_W'(N_CH - 1)) ?
                   '0 : gnt_idx + CH_W'(1);
      end
    end
  end

  assign pending       = pend_q;
  assign evt.evt_valid = v_q;
  assign evt.evt_ch    = ch_q;
  assign evt.evt_cnt   = cnt_o_q;
  assign evt.evt_sat   = sat_o_q;

endmodule

// File: tb/tb_seqcheck_event_arb.sv
// tb_seqcheck_event_arb: directed scenarios plus random traffic
// checked every cycle against a queue-free behavioural model.
module tb_seqcheck_event_arb;
  import seqcheck_pkg::*;

  localparam int N    = 4;
  localparam int CW   = 2;
  localparam int CHW  = 2;
  localparam int MAXC = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] hit;
  logic [N-1:0] ch_en;
  logic [N-1:0] pending;

  seqcheck_event_arb_if #(.CH_W(CHW), .CNT_W(CW)) evt_if ();

  seqcheck_event_arb #(.N_CH(N), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .hit     (hit),
    .ch_en   (ch_en),
    .pending (pending),
    .evt     (evt_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural model: outstanding event plus per-channel tallies
  bit   m_pend [N];
  int   m_cnt  [N];
  bit   m_sat  [N];
  int   m_ptr;
  bit   m_valid;
  evt_t m_evt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
      end
      m_ptr = 0; m_valid = 0; m_evt = '0;
    end else begin
      if (!m_valid || evt_if.evt_ready) begin
        int g;
        g = -1;
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (g < 0 && m_pend[c] && ch_en[c]) g = c;
        end
        m_valid = (g >= 0);
        if (g >= 0) begin
          m_evt.ch  = MAX_CH_W'(g);
          m_evt.cnt = MAX_CNT_W'(m_cnt[g]);
          m_evt.sat = m_sat[g];
          m_pend[g] = 0; m_cnt[g] = 0; m_sat[g] = 0;
          m_ptr = (g + 1) % N;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!ch_en[i]) begin
          m_pend[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
        end else if (hit[i]) begin
          if (!m_pend[i]) begin
            m_pend[i] = 1; m_cnt[i] = 1; m_sat[i] = 0;
          end else if (m_cnt[i] == MAXC) m_sat[i] = 1;
          else m_cnt[i]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      int mp;
      mp = 0;
      for (int i = 0; i < N; i++) if (m_pend[i]) mp |= (1 << i);
      chk("m_valid", int'(evt_if.evt_valid), int'(m_valid));
      chk("m_pending", int'(pending), mp);
      if (m_valid) begin
        chk("m_ch", int'(evt_if.evt_ch), int'(m_evt.ch));
        chk("m_cnt", int'(evt_if.evt_cnt), int'(m_evt.cnt));
        chk("m_sat", int'(evt_if.evt_sat), int'(m_evt.sat));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_evt(input string nm, input int ch,
                         input int cnt, input int sat);
    chk({nm, "_valid"}, int'(evt_if.evt_valid), 1);
    chk({nm, "_ch"}, int'(evt_if.evt_ch), ch);
    chk({nm, "_cnt"}, int'(evt_if.evt_cnt), cnt);
    chk({nm, "_sat"}, int'(evt_if.evt_sat), sat);
  endtask

  initial begin
    rst_n = 1'b0;
    hit = '0;
    ch_en = '1;
    evt_if.evt_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_valid", int'(evt_if.evt_valid), 0);
    chk("rst_ch", int'(evt_if.evt_ch), 0);
    chk("rst_cnt", int'(evt_if.evt_cnt), 0);
    chk("rst_sat", int'(evt_if.evt_sat), 0);
    chk("rst_pending", int'(pending), 0);

    // single hit latency
    hit = 4'b0100; tick(); hit = '0;
    chk("t1_pending", int'(pending), 4'b0100);
    tick();
    chk_evt("t1", 2, 1, 0);
    chk("t1_pend_clr", int'(pending), 0);
    tick();
    chk("t1_idle", int'(evt_if.evt_valid), 0);

    // back-pressure coalescing
    evt_if.evt_ready = 1'b0;
    hit = 4'b0010; tick(); hit = '0; tick();
    chk_evt("t2a", 1, 1, 0);
    hit = 4'b0010; tick(); hit = '0; tick();
    hit = 4'b0010; tick(); hit = '0; tick();
    chk_evt("t2hold", 1, 1, 0);
    chk("t2_pending", int'(pending), 4'b0010);
    evt_if.evt_ready = 1'b1; tick();
    chk_evt("t2b", 1, 2, 0);
    tick();
    chk("t2_idle", int'(evt_if.evt_valid), 0);

    // saturation
    evt_if.evt_ready = 1'b0;
    hit = 4'b1000; tick(); hit = '0; tick();
    hit = 4'b0001;
    repeat (5) tick();
    hit = '0;
    evt_if.evt_ready = 1'b1; tick();
    chk_evt("t3", 0, 3, 1);
    tick();

    // simultaneous hits, rr order from 0
    do_reset();
    hit = 4'b1011; tick(); hit = '0;
    chk("t4_pending", int'(pending), 4'b1011);
    tick(); chk_evt("t4a", 0, 1, 0);
    tick(); chk_evt("t4b", 1, 1, 0);
    tick(); chk_evt("t4c", 3, 1, 0);
    tick(); chk("t4_idle", int'(evt_if.evt_valid), 0);

    // hit during its own grant
    evt_if.evt_ready = 1'b0;
    hit = 4'b0001; tick(); hit = '0; tick();
    hit = 4'b0100; tick(); tick();
    evt_if.evt_ready = 1'b1; tick(); hit = '0;
    chk_evt("t5a", 2, 2, 0);
    chk("t5_pending", int'(pending), 4'b0100);
    tick(); chk_evt("t5b", 2, 1, 0);
    tick(); chk("t5_idle", int'(evt_if.evt_valid), 0);

    // channel disable flush, then async reset mid-stall
    evt_if.evt_ready = 1'b0;
    hit = 4'b0001; tick(); hit = '0; tick();
    hit = 4'b0010; tick(); tick(); hit = '0;
    chk("t6_pending", int'(pending), 4'b0010);
    ch_en = 4'b1101; tick(); ch_en = '1;
    chk("t6_flushed", int'(pending), 0);
    tick();
    chk_evt("t6hold", 0, 1, 0);
    evt_if.evt_ready = 1'b1; tick();
    chk("t6_no_ch1", int'(evt_if.evt_valid), 0);
    evt_if.evt_ready = 1'b0;
    hit = 4'b1000; tick(); hit = '0; tick();
    chk_evt("t6c", 3, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(evt_if.evt_valid), 0);
    chk("t6_rst_pend", int'(pending), 0);
    tick();
    rst_n = 1'b1;

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      hit = N'($urandom & $urandom);
      ch_en = ($urandom_range(0, 15) == 0) ? N'($urandom) : '1;
      if (cyc % 200 < 60) evt_if.evt_ready = ($urandom_range(0, 5) == 0);
      else evt_if.evt_ready = ($urandom_range(0, 2) != 0);
      if (cyc == 1500) begin
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    hit = '0;
    evt_if.evt_ready = 1'b1;
    repeat (N + 2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seqcheck_event_arb.md
# seqcheck_event_arb

Collects 1-cycle `hit` pulses from `N_CH` parallel sequence-check channels and shares a single event output port between them. Each hit is captured into a per-channel pending flag with a saturating coalesce count. The block then serialises pending channels onto a valid/ready event stream using round-robin arbitration. It sits between the bank of sequence checkers and the downstream event consumer (logger/interrupt block).

## Interface
- `N_CH`, default 4: number of channels, range 2..16.
- `CNT_W`, default 4: coalesce-count width, range ≥2; count saturates at 2^CNT_W−1.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `hit`  in  N_CH  per-channel 1-cycle hit pulses, synchronous to `clk`.
- `ch_en`  in  N_CH  per-channel enable; 0 = ignore hits and flush pending state.
- `evt_valid`  out  1  event available.
- `evt_ready`  in  1  consumer accepts the event when high with `evt_valid`.
- `evt_ch`  out  CH_W  channel index of the event; CH_W = clog2(N_CH).
- `evt_cnt`  out  CNT_W  number of hits coalesced into this event, ≥1.
- `evt_sat`  out  1  count saturated; hits were lost in the count.
- `pending`  out  N_CH  per-channel pending flags (status).

## Operation
- Per-channel state: `pend`, `cnt[CNT_W]`, `sat`.
- Hit capture, when `hit[i] & ch_en[i]`:
  - If not pending: set `pend=1`, `cnt=1`, `sat=0`.
  - If pending: `cnt` increments. At max, `cnt` holds and `sat` becomes 1.
- `ch_en[i]=0`: `pend`, `cnt` and `sat` are cleared every cycle and hits are ignored. An event already in the output register is unaffected.
- Output register has a single entry. It loads when `!evt_valid || evt_ready` (empty, or being drained this cycle).
- Selection is round-robin among channels with `pend` set, searching upward from `rr_ptr` with wrap. On load:
  - `evt_ch`, `evt_cnt`, `evt_sat` take the snapshot of that channel.
  - That channel's `pend`, `cnt` and `sat` are cleared.
  - `rr_ptr` becomes granted+1 mod N_CH.
- If no channel is pending on a load opportunity, `evt_valid` goes 0.
- Simultaneous hit on the granted channel in its grant cycle:
  - The snapshot excludes that hit.
  - The channel restarts with `pend=1`, `cnt=1`, `sat=0`.
- Simultaneous hits on several channels are all captured in the same cycle. None are dropped.
- Handshake: once `evt_valid=1`, it and all `evt_*` outputs hold stable until the cycle with `evt_ready=1`. `evt_ready` may be high while `evt_valid=0`; this has no effect.

## Timing
- Reset values: `evt_valid=0`, `evt_ch=0`, `evt_cnt=0`, `evt_sat=0`, `pending=0`. Internal state resets to `rr_ptr=0`, all `pend`/`cnt`/`sat` = 0.
- Reset mid-operation clears everything immediately, including an un-accepted event. Nothing is replayed after reset.
- Latency, for a hit sampled at edge E with the output free:
  - `pend` is set at E.
  - `evt_valid=1` from edge E+1.
  - `pending[i]` is visible from E and clears at E+1 (the grant edge).
- Throughput: one event per cycle while `evt_ready` is held high and channels remain pending.
- Back-pressure: while `evt_ready=0`, hits keep coalescing into `cnt`. There is no loss except counts beyond saturation, which are flagged by `sat`.
- Fairness: a continuously pending channel is granted at least once every N_CH accepted events.

## Structure
- Package `seqcheck_pkg` holds:
  - CH_W computation as a function: clog2 with minimum 1.
  - Count max constant: (1<<CNT_W)−1.
  - Event struct `{ch, cnt, sat}`, reused by the downstream logger.
- Sub-module `seqcheck_rr_pick`: combinational rotate-priority pick.
  - Inputs: `req[N_CH]`, `ptr`.
  - Outputs: `gnt_valid`, `gnt_idx`.
- The top module holds the per-channel capture registers, the output register and `rr_ptr`.

## Test plan
1. Reset, then a single `hit[2]` at edge E with `evt_ready=1` → `evt_valid` at E+1 with `evt_ch=2`, `evt_cnt=1`, `evt_sat=0`; `evt_valid` 0 at E+2.
2. `evt_ready=0`, then 3 hits on ch1 → a single event `ch=1`, `cnt=1` (first hit loaded immediately) that holds stable. The next 2 hits coalesce. After `evt_ready=1`, a second event `ch=1`, `cnt=2` follows.
3. `CNT_W=2`, `evt_ready=0`, output occupied, 5 hits on ch0 → after release, `evt_cnt=3` and `evt_sat=1`.
4. Hits on ch0, ch1 and ch3 in the same cycle with `rr_ptr=0`, `evt_ready=1` → events in order 0, 1, 3 on consecutive cycles, each `cnt=1`.
5. Grant ch2 while a new `hit[2]` arrives in the same cycle → the event has `cnt` equal to the pre-grant count, and a follow-up event `ch=2`, `cnt=1` arrives.
6. Pending ch1 with `cnt=2`, then `ch_en[1]=0` for one cycle → `pending[1]=0` and no ch1 event is emitted. Asserting `rst_n=0` mid-stall then drops `evt_valid` to 0 asynchronously.
